code_histogram: RTL

CODE_HISTOGRAM -- requirements
Module: code_histogram

---
 rtl/code_histogram_pkg.sv | 19 +
 rtl/code_histogram_hist_ram.sv | 28 ++
 rtl/code_histogram.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/code_histogram_pkg.sv
// code_histogram_pkg: shared sizing constants and the FSM state encoding
// for the ADC code histogram block.
package code_histogram_pkg;

  localparam int CODE_W     = 10;
  localparam int CNT_W      = 16;
  localparam int DEPTH_RAM  = 1024;
  localparam int FIFO_W     = 10;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    DUMP  = 3'd3,
    DONE  = 3'd4
  } hist_state_e;

endpackage

// File: rtl/code_histogram_hist_ram.sv
// hist_ram: simple dual-port bin memory, one write port and one read port,
// synchronous read with one cycle of latency, contents not reset.
module hist_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  // Write and registered read; a same-address read returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/code_histogram.sv
// code_histogram: clears a bin RAM, accumulates ADC codes with a two-stage
// read-modify-write pipeline, then dumps every bin in ascending order.
// Build option: define HIST_SATURATE_EN to make bins stick at all-ones
// instead of wrapping to zero.
module code_histogram #(
  parameter int CODE_W = code_histogram_pkg::CODE_W,
  parameter int CNT_W  = code_histogram_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_data,
  input  logic              code_valid,
  output logic              code_ready,
  input  logic              stop,
  output logic [CODE_W-1:0] dump_addr,
  output logic [CNT_W-1:0]  dump_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic              done,
  output logic              sat
);

  import code_histogram_pkg::*;

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_n;

  hist_state_e       state_q, state_d;
  logic [CODE_W-1:0] clr_addr_q, clr_addr_d;
  logic              code_ready_q, code_ready_d;
  logic              p1_valid_q, p1_valid_d;
  logic [CODE_W-1:0] p1_addr_q, p1_addr_d;
  logic              fwd_valid_q, fwd_valid_d;
  logic [CNT_W-1:0]  fwd_val_q, fwd_val_d;
  logic [CODE_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic              fetch_done_q, fetch_done_d;
  logic              pf_valid_q, pf_valid_d;
  logic [CODE_W-1:0] pf_addr_q, pf_addr_d;
  logic              dump_valid_q, dump_valid_d;
  logic [CODE_W-1:0] dump_addr_q, dump_addr_d;
  logic [CNT_W-1:0]  dump_data_q, dump_data_d;
  logic              done_q, done_d;
  logic              sat_q, sat_d;

  logic              accept;
  logic              out_advance;
  logic [CNT_W-1:0]  base_cnt;
  logic [CNT_W-1:0]  inc_cnt;
  logic              ram_wr_en;
  logic [CODE_W-1:0] ram_wr_addr;
  logic [CNT_W-1:0]  ram_wr_data;
  logic [CODE_W-1:0] ram_rd_addr;
  logic [CNT_W-1:0]  ram_rd_data;

  // Reset release is shifted in on clk; assertion still propagates at once.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Two-flop release synchroniser for the external active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n = rst_sync_q[1];

  assign accept      = code_valid && code_ready_q;
  assign out_advance = !dump_valid_q || dump_ready;

  // Second pipeline stage: pick the forwarded count on a back-to-back hit.
  always_comb begin
    base_cnt = fwd_valid_q ? fwd_val_q : ram_rd_data;
`ifdef HIST_SATURATE_EN
    inc_cnt = (base_cnt == '1) ? base_cnt : base_cnt + 1'b1;
`else
    inc_cnt = base_cnt + 1'b1;
`endif
  end

  // RAM port steering: clear writes in CLEAR, prefetch reads in DUMP.
  always_comb begin
    ram_wr_en   = p1_valid_q;
    ram_wr_addr = p1_addr_q;
    ram_wr_data = inc_cnt;
    ram_rd_addr = code_data;
    if (state_q == CLEAR) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = clr_addr_q;
      ram_wr_data = '0;
    end
    if (state_q == DUMP) begin
      ram_rd_addr = (out_advance && !fetch_done_q) ? fetch_ptr_q : pf_addr_q;
    end
  end

  hist_ram #(
    .ADDR_W (CODE_W),
    .DATA_W (CNT_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  // Next-state and output computation for the whole controller.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    code_ready_d = 1'b0;
    p1_valid_d   = accept;
    p1_addr_d    = code_data;
    fwd_valid_d  = accept && p1_valid_q && (code_data == p1_addr_q);
    fwd_val_d    = inc_cnt;
    fetch_ptr_d  = fetch_ptr_q;
    fetch_done_d = fetch_done_q;
    pf_valid_d   = pf_valid_q;
    pf_addr_d    = pf_addr_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    done_d       = done_q;
    sat_d        = sat_q || (p1_valid_q && (inc_cnt == '1));

    case (state_q)
      CLEAR: begin
        sat_d      = 1'b0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == '1) begin
          state_d      = ACCUM;
          code_ready_d = !stop;
        end
      end
      ACCUM: begin
        if (stop) begin
          state_d = DRAIN;
        end else begin
          code_ready_d = 1'b1;
        end
      end
      DRAIN: begin
        state_d      = DUMP;
        fetch_ptr_d  = '0;
        fetch_done_d = 1'b0;
        pf_valid_d   = 1'b0;
        dump_valid_d = 1'b0;
      end
      DUMP: begin
        if (out_advance) begin
          dump_valid_d = pf_valid_q;
          dump_addr_d  = pf_addr_q;
          dump_data_d  = ram_rd_data;
          if (!fetch_done_q) begin
            pf_valid_d   = 1'b1;
            pf_addr_d    = fetch_ptr_q;
            fetch_ptr_d  = fetch_ptr_q + 1'b1;
            fetch_done_d = (fetch_ptr_q == '1);
          end else begin
            pf_valid_d = 1'b0;
          end
        end
        if (dump_valid_q && dump_ready && (dump_addr_q == '1)) begin
          state_d      = DONE;
          dump_valid_d = 1'b0;
          done_d       = 1'b1;
        end
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // State register; everything restarts from CLEAR on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CLEAR;
      clr_addr_q   <= '0;
      code_ready_q <= 1'b0;
      p1_valid_q   <= 1'b0;
      p1_addr_q    <= '0;
      fwd_valid_q  <= 1'b0;
      fwd_val_q    <= '0;
      fetch_ptr_q  <= '0;
      fetch_done_q <= 1'b0;
      pf_valid_q   <= 1'b0;
      pf_addr_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      done_q       <= 1'b0;
      sat_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      code_ready_q <= code_ready_d;
      p1_valid_q   <= p1_valid_d;
      p1_addr_q    <= p1_addr_d;
      fwd_valid_q  <= fwd_valid_d;
      fwd_val_q    <= fwd_val_d;
      fetch_ptr_q  <= fetch_ptr_d;
      fetch_done_q <= fetch_done_d;
      pf_valid_q   <= pf_valid_d;
      pf_addr_q    <= pf_addr_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      done_q       <= done_d;
      sat_q        <= sat_d;
    end
  end

  assign code_ready = code_ready_q;
  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign done       = done_q;
  assign sat        = sat_q;

endmodule
